// File: rtl/fpu_mul_arbiter.sv
// ---------------------------------------------------------------------------
// fpu_mul_arbiter : two-requester round-robin front end for a shared FP
//                   multiplier, with rounding-mode resolution and watchdog.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fpu_mul_arbiter #(
   parameter int TAG_W    = 4,
   parameter int WDOG_CYC = 64
) (
   input  logic             clk,
   input  logic             rst_n,

   input  logic             req0_valid_i,
   output logic             req0_ready_o,
   input  logic [31:0]      req0_a_i,
   input  logic [31:0]      req0_b_i,
   input  logic [2:0]       req0_rm_i,
   input  logic [TAG_W-1:0] req0_tag_i,

   input  logic             req1_valid_i,
   output logic             req1_ready_o,
   input  logic [31:0]      req1_a_i,
   input  logic [31:0]      req1_b_i,
   input  logic [2:0]       req1_rm_i,
   input  logic [TAG_W-1:0] req1_tag_i,

   input  logic [2:0]       frm_i,

   output logic             mul_start_o,
   output logic [31:0]      mul_a_o,
   output logic [31:0]      mul_b_o,
   output logic [2:0]       mul_rm_o,
   input  logic [31:0]      mul_result_i,
   input  logic [3:0]       mul_flags_i,
   input  logic             mul_done_i,

   output logic             resp_valid_o,
   input  logic             resp_ready_i,
   output logic             resp_id_o,
   output logic [TAG_W-1:0] resp_tag_o,
   output logic [31:0]      resp_result_o,
   output logic [4:0]       resp_flags_o
);

   localparam int          CNT_W = $clog2(WDOG_CYC + 1);
   localparam logic [31:0] QNAN  = 32'h7FC0_0000;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_BUSY  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic               rr_q, rr_d;
   logic [CNT_W-1:0]   wdog_q, wdog_d;
   logic [31:0]        a_q, a_d;
   logic [31:0]        b_q, b_d;
   logic [2:0]         rm_q, rm_d;
   logic [TAG_W-1:0]   tag_q, tag_d;
   logic               id_q, id_d;
   logic [31:0]        result_q, result_d;
   logic [4:0]         flags_q, flags_d;

   logic               grant_id;
   logic [2:0]         sel_rm;
   logic [2:0]         eff_rm;

   // rr_q names the requester that wins the next tie.
   always_comb begin
      grant_id = (req0_valid_i && req1_valid_i) ? rr_q : req1_valid_i;
      sel_rm   = grant_id ? req1_rm_i : req0_rm_i;
      eff_rm   = (sel_rm == 3'b111) ? frm_i : sel_rm;
   end

   always_comb begin
      state_d      = state_q;
      rr_d         = rr_q;
      wdog_d       = wdog_q;
      a_d          = a_q;
      b_d          = b_q;
      rm_d         = rm_q;
      tag_d        = tag_q;
      id_d         = id_q;
      result_d     = result_q;
      flags_d      = flags_q;
      req0_ready_o = 1'b0;
      req1_ready_o = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (req0_valid_i || req1_valid_i) begin
               req0_ready_o = ~grant_id;
               req1_ready_o = grant_id;
               a_d   = grant_id ? req1_a_i   : req0_a_i;
               b_d   = grant_id ? req1_b_i   : req0_b_i;
               tag_d = grant_id ? req1_tag_i : req0_tag_i;
               rm_d  = eff_rm;
               id_d  = grant_id;
               rr_d  = ~grant_id;
               if (eff_rm == 3'b101 || eff_rm == 3'b110) begin
                  result_d = QNAN;
                  flags_d  = 5'b01000;
                  state_d  = S_RESP;
               end else begin
                  state_d  = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            wdog_d  = '0;
            state_d = S_BUSY;
         end
         S_BUSY: begin
            wdog_d = wdog_q + 1'b1;
            // A completion arriving on the expiry cycle still wins.
            if (mul_done_i) begin
               result_d = mul_result_i;
               flags_d  = {1'b0, mul_flags_i};
               state_d  = S_RESP;
            end else if (wdog_q == CNT_W'(WDOG_CYC - 1)) begin
               result_d = QNAN;
               flags_d  = 5'b10000;
               state_d  = S_RESP;
            end
         end
         S_RESP: begin
            if (resp_ready_i) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         rr_q     <= 1'b0;
         wdog_q   <= '0;
         a_q      <= '0;
         b_q      <= '0;
         rm_q     <= '0;
         tag_q    <= '0;
         id_q     <= 1'b0;
         result_q <= '0;
         flags_q  <= '0;
      end else begin
         state_q  <= state_d;
         rr_q     <= rr_d;
         wdog_q   <= wdog_d;
         a_q      <= a_d;
         b_q      <= b_d;
         rm_q     <= rm_d;
         tag_q    <= tag_d;
         id_q     <= id_d;
         result_q <= result_d;
         flags_q  <= flags_d;
      end
   end

   assign mul_start_o   = (state_q == S_ISSUE);
   assign mul_a_o       = a_q;
   assign mul_b_o       = b_q;
   assign mul_rm_o      = rm_q;
   assign resp_valid_o  = (state_q == S_RESP);
   assign resp_id_o     = id_q;
   assign resp_tag_o    = tag_q;
   assign resp_result_o = result_q;
   assign resp_flags_o  = flags_q;

endmodule

`default_nettype wire

// File: tb/tb_fpu_mul_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fpu_mul_arbiter : directed scoreboard bench for fpu_mul_arbiter.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fpu_mul_arbiter;

   localparam int          TAG_W    = 4;
   localparam int          WDOG_CYC = 64;
   localparam logic [31:0] QNAN     = 32'h7FC0_0000;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             req0_valid_i, req1_valid_i;
   logic             req0_ready_o, req1_ready_o;
   logic [31:0]      req0_a_i, req0_b_i, req1_a_i, req1_b_i;
   logic [2:0]       req0_rm_i, req1_rm_i, frm_i;
   logic [TAG_W-1:0] req0_tag_i, req1_tag_i;
   logic             mul_start_o;
   logic [31:0]      mul_a_o, mul_b_o;
   logic [2:0]       mul_rm_o;
   logic [31:0]      mul_result_i;
   logic [3:0]       mul_flags_i;
   logic             mul_done_i;
   logic             resp_valid_o, resp_ready_i, resp_id_o;
   logic [TAG_W-1:0] resp_tag_o;
   logic [31:0]      resp_result_o;
   logic [4:0]       resp_flags_o;

   fpu_mul_arbiter #(.TAG_W(TAG_W), .WDOG_CYC(WDOG_CYC)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
      .req0_a_i(req0_a_i), .req0_b_i(req0_b_i), .req0_rm_i(req0_rm_i), .req0_tag_i(req0_tag_i),
      .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
      .req1_a_i(req1_a_i), .req1_b_i(req1_b_i), .req1_rm_i(req1_rm_i), .req1_tag_i(req1_tag_i),
      .frm_i(frm_i),
      .mul_start_o(mul_start_o), .mul_a_o(mul_a_o), .mul_b_o(mul_b_o), .mul_rm_o(mul_rm_o),
      .mul_result_i(mul_result_i), .mul_flags_i(mul_flags_i), .mul_done_i(mul_done_i),
      .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_id_o(resp_id_o),
      .resp_tag_o(resp_tag_o), .resp_result_o(resp_result_o), .resp_flags_o(resp_flags_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic             id;
      logic [TAG_W-1:0] tag;
      logic [31:0]      result;
      logic [4:0]       flags;
   } resp_t;

   resp_t exp_q[$];
   int    grant_log[$];
   int    checks = 0;
   int    failures = 0;
   int    cyc = 0;
   int    grant_cyc = 0;
   int    resp_cyc = 0;
   int    n_start = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Scoreboard monitor: every accepted response is popped and compared.
   initial begin
      resp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && resp_valid_o && resp_ready_i) begin
            resp_cyc = cyc;
            if (exp_q.size() == 0) begin
               chk("unexpected_resp", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("resp_id", resp_id_o, e.id);
               chk("resp_tag", resp_tag_o, e.tag);
               chk("resp_result", resp_result_o, e.result);
               chk("resp_flags", resp_flags_o, e.flags);
            end
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         if (mul_start_o) n_start++;
         if (req0_ready_o || req1_ready_o) begin
            if (req0_ready_o && req1_ready_o) chk("ready_onehot", 1, 0);
            grant_log.push_back(req1_ready_o ? 1 : 0);
            grant_cyc = cyc;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   task automatic drive_req(input bit n, input bit v, input logic [31:0] a, input logic [31:0] b,
                            input logic [2:0] rm, input logic [TAG_W-1:0] tag);
      if (!n) begin
         req0_valid_i = v; req0_a_i = a; req0_b_i = b; req0_rm_i = rm; req0_tag_i = tag;
      end else begin
         req1_valid_i = v; req1_a_i = a; req1_b_i = b; req1_rm_i = rm; req1_tag_i = tag;
      end
   endtask

   task automatic issue_req(input bit n, input logic [31:0] a, input logic [31:0] b,
                            input logic [2:0] rm, input logic [TAG_W-1:0] tag);
      int k = 0;
      drive_req(n, 1'b1, a, b, rm, tag);
      @(negedge clk);
      while (!(n ? req1_ready_o : req0_ready_o) && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("grant_seen", n ? req1_ready_o : req0_ready_o, 1);
      tick();
      drive_req(n, 1'b0, a, b, rm, tag);
   endtask

   task automatic wait_grants(input int n);
      int k;
      repeat (n) begin
         k = 0;
         @(negedge clk);
         while (!(req0_ready_o || req1_ready_o) && k < 200) begin
            @(negedge clk);
            k++;
         end
         tick();
      end
      req0_valid_i = 1'b0;
      req1_valid_i = 1'b0;
   endtask

   // Multiplier stand-in: checks the command, then completes after dly BUSY cycles.
   task automatic mul_reply(input logic [31:0] ea, input logic [31:0] eb, input logic [2:0] erm,
                            input logic [31:0] res, input logic [3:0] fl, input int dly,
                            input logic [2:0] frm_busy);
      int k = 0;
      @(negedge clk);
      while (!mul_start_o && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("mul_start_seen", mul_start_o, 1);
      chk("start_latency", cyc - grant_cyc, 1);
      chk("mul_cmd", {mul_a_o, mul_b_o, mul_rm_o}, {ea, eb, erm});
      tick();
      frm_i = frm_busy;
      repeat (dly) begin
         @(negedge clk);
         chk("mul_hold", {mul_a_o, mul_rm_o, mul_start_o}, {ea, erm, 1'b0});
      end
      tick();
      mul_done_i = 1'b1; mul_result_i = res; mul_flags_i = fl;
      tick();
      mul_done_i = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int k = 0;
      while (exp_q.size() != 0 && k < 300) begin
         @(negedge clk);
         k++;
      end
      chk(name, exp_q.size(), 0);
      tick();
   endtask

   task automatic chk_zero(input string name);
      chk({name, "_ctrl"}, {mul_start_o, resp_valid_o, req0_ready_o, req1_ready_o}, 0);
      chk({name, "_mul"}, {mul_a_o, mul_b_o}, 0);
      chk({name, "_resp"}, {resp_result_o, resp_flags_o, resp_tag_o, resp_id_o}, 0);
   endtask

   initial begin
      int g;
      int k;
      drive_req(0, 1'b0, 0, 0, 0, 0);
      drive_req(1, 1'b0, 0, 0, 0, 0);
      frm_i = 3'b000; mul_done_i = 1'b0; mul_result_i = 0; mul_flags_i = 0;
      resp_ready_i = 1'b1;
      repeat (2) @(negedge clk);
      chk_zero("reset");
      tick();
      rst_n = 1'b1;
      tick();

      // 2.0 * 3.0 = 6.0 from req0
      exp_q.push_back('{1'b0, 4'd5, 32'h40C0_0000, 5'b00000});
      fork
         issue_req(0, 32'h4000_0000, 32'h4040_0000, 3'b000, 4'd5);
         mul_reply(32'h4000_0000, 32'h4040_0000, 3'b000, 32'h40C0_0000, 4'b0000, 3, 3'b000);
      join
      wait_drain("drain_single");

      // Dynamic rm: frm=011 resolved at grant, frm drops to 000 during BUSY
      frm_i = 3'b011;
      exp_q.push_back('{1'b1, 4'd7, 32'h4020_0000, 5'b00001});
      fork
         issue_req(1, 32'h40A0_0000, 32'h3F00_0000, 3'b111, 4'd7);
         mul_reply(32'h40A0_0000, 32'h3F00_0000, 3'b011, 32'h4020_0000, 4'b0001, 5, 3'b000);
      join
      wait_drain("drain_dynrm");

      // Tie: both valid for four transactions
      grant_log.delete();
      exp_q.push_back('{1'b0, 4'd1, 32'h4000_0000, 5'b00000});
      exp_q.push_back('{1'b1, 4'd2, 32'h4140_0000, 5'b00000});
      exp_q.push_back('{1'b0, 4'd1, 32'h4000_0000, 5'b00000});
      exp_q.push_back('{1'b1, 4'd2, 32'h4140_0000, 5'b00000});
      drive_req(0, 1'b1, 32'h3F80_0000, 32'h4000_0000, 3'b000, 4'd1);
      drive_req(1, 1'b1, 32'h4040_0000, 32'h4080_0000, 3'b001, 4'd2);
      fork
         wait_grants(4);
         begin
            mul_reply(32'h3F80_0000, 32'h4000_0000, 3'b000, 32'h4000_0000, 4'b0000, 2, 3'b000);
            mul_reply(32'h4040_0000, 32'h4080_0000, 3'b001, 32'h4140_0000, 4'b0000, 2, 3'b000);
            mul_reply(32'h3F80_0000, 32'h4000_0000, 3'b000, 32'h4000_0000, 4'b0000, 2, 3'b000);
            mul_reply(32'h4040_0000, 32'h4080_0000, 3'b001, 32'h4140_0000, 4'b0000, 2, 3'b000);
         end
      join
      wait_drain("drain_tie");
      chk("tie_count", grant_log.size(), 4);
      for (int i = 0; i < grant_log.size() && i < 4; i++) chk("tie_order", grant_log[i], i % 2);

      // Invalid rounding mode 101: no multiplier command
      n_start = 0;
      exp_q.push_back('{1'b0, 4'd9, QNAN, 5'b01000});
      issue_req(0, 32'h3F80_0000, 32'h3F80_0000, 3'b101, 4'd9);
      g = grant_cyc;
      wait_drain("drain_badrm");
      chk("badrm_latency", (resp_cyc - g >= 1) && (resp_cyc - g <= 2), 1);
      repeat (3) tick();
      chk("badrm_no_start", n_start, 0);

      // Watchdog: the unit never answers
      exp_q.push_back('{1'b1, 4'd3, QNAN, 5'b10000});
      issue_req(1, 32'h4000_0000, 32'h4000_0000, 3'b000, 4'd3);
      g = grant_cyc;
      wait_drain("drain_wdog");
      chk("wdog_latency", (resp_cyc - g >= WDOG_CYC + 1) && (resp_cyc - g <= WDOG_CYC + 2), 1);
      mul_done_i = 1'b1; mul_result_i = 32'hDEAD_BEEF; mul_flags_i = 4'hF;
      tick();
      mul_done_i = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("late_done_ignored", {resp_valid_o, resp_result_o, resp_flags_o}, {1'b0, QNAN, 5'b10000});
      end
      tick();

      // Backpressure: response held, competing request not granted
      resp_ready_i = 1'b0;
      exp_q.push_back('{1'b0, 4'd4, 32'h4040_0000, 5'b00001});
      fork
         issue_req(0, 32'h3FC0_0000, 32'h4000_0000, 3'b010, 4'd4);
         mul_reply(32'h3FC0_0000, 32'h4000_0000, 3'b010, 32'h4040_0000, 4'b0001, 2, 3'b000);
      join
      k = 0;
      while (!resp_valid_o && k < 50) begin
         @(negedge clk);
         k++;
      end
      drive_req(1, 1'b1, 32'h4000_0000, 32'h4000_0000, 3'b000, 4'd8);
      repeat (10) begin
         @(negedge clk);
         chk("bp_hold", {resp_valid_o, resp_id_o, resp_tag_o, resp_result_o, resp_flags_o, req1_ready_o},
             {1'b1, 1'b0, 4'd4, 32'h4040_0000, 5'b00001, 1'b0});
      end
      tick();
      req1_valid_i = 1'b0;
      resp_ready_i = 1'b1;
      wait_drain("drain_bp");

      // Reset mid-BUSY abandons the transaction
      drive_req(1, 1'b1, 32'h4000_0000, 32'h4040_0000, 3'b000, 4'd6);
      k = 0;
      @(negedge clk);
      while (!mul_start_o && k < 50) begin
         @(negedge clk);
         k++;
      end
      req1_valid_i = 1'b0;
      repeat (3) tick();
      rst_n = 1'b0;
      #2;
      chk_zero("async_rst");
      tick();
      rst_n = 1'b1;
      repeat (8) begin
         @(negedge clk);
         chk("rst_no_resp", {resp_valid_o, mul_start_o}, 0);
      end
      tick();

      // After reset req0 wins the tie; invalid-rm grants still rotate
      grant_log.delete();
      exp_q.push_back('{1'b0, 4'd10, QNAN, 5'b01000});
      exp_q.push_back('{1'b1, 4'd11, QNAN, 5'b01000});
      drive_req(0, 1'b1, 32'h3F80_0000, 32'h3F80_0000, 3'b110, 4'd10);
      drive_req(1, 1'b1, 32'h3F80_0000, 32'h3F80_0000, 3'b110, 4'd11);
      wait_grants(2);
      wait_drain("drain_post_rst");
      chk("post_rst_count", grant_log.size(), 2);
      for (int i = 0; i < grant_log.size() && i < 2; i++) chk("post_rst_order", grant_log[i], i);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
